// File: rtl/seq_pattern_detect_if.sv
// -----------------------------------------------------------------------------
// seq_pattern_detect_if
//
// Purpose:
//   Groups the serial input qualifier/data pair and the detector's status
//   outputs into one bundle. The upstream pipeline (or a bench) takes the
//   master view. The detector takes the slave view.
//
// Parameters:
//   CNT_W      width of the match counter carried on match_cnt
//
// Signals:
//   in_valid   master -> slave  in_bit is meaningful this cycle
//   in_bit     master -> slave  serial data bit
//   match      slave -> master  one-cycle registered match pulse
//   match_cnt  slave -> master  saturating number of matches since reset
//   primed     slave -> master  PAT_W bits accepted since reset/restart
// -----------------------------------------------------------------------------
interface seq_pattern_detect_if #(
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_bit;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             primed;

  modport master (
    output in_valid,
    output in_bit,
    input  match,
    input  match_cnt,
    input  primed
  );

  modport slave (
    input  in_valid,
    input  in_bit,
    output match,
    output match_cnt,
    output primed
  );
endinterface : seq_pattern_detect_if

// File: rtl/seq_pattern_detect.sv
// -----------------------------------------------------------------------------
// seq_pattern_detect
//
// Purpose:
//   Serial pattern detector that sits after the shift stage. It accepts one
//   bit per clock when in_valid is high and keeps the last PAT_W accepted
//   bits. It raises a one-cycle registered pulse each time those bits equal
//   PATTERN (bit 0 = most recent bit). A saturating counter records the
//   matches.
//
// Parameters:
//   PAT_W    pattern length in bits (>= 2)
//   PATTERN  pattern to detect; bit 0 is the most recently received bit
//   CNT_W    width of the saturating match counter
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   bus      seq_pattern_detect_if.slave:
//              in_valid, in_bit  -> serial input (bit sampled only if valid)
//              match             <- pulse, one clk after the completing bit
//              match_cnt         <- matches since reset, saturating
//              primed            <- PAT_W bits accepted since reset/restart
//
// Build option:
//   SEQ_PATTERN_NO_OVERLAP_EN  when defined, a hit clears the history. The
//                              next match then needs PAT_W fresh bits, and
//                              primed drops for that restart. When undefined,
//                              overlapping matches are detected.
// -----------------------------------------------------------------------------
module seq_pattern_detect #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               CNT_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_pattern_detect_if.slave  bus
);

  localparam int               FILL_W   = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_HIT = FILL_W'(PAT_W - 1);

  // Architectural state
  logic [PAT_W-1:0]  shreg;
  logic [FILL_W-1:0] fill;
  logic              match_r;
  logic [CNT_W-1:0]  match_cnt_r;

  // Combinational next values
  logic [PAT_W-1:0]  shreg_next;
  logic [FILL_W-1:0] fill_inc;
  logic              hit;

  // NOTE: every always_comb output gets a default before any condition, so a
  // missed branch can never leave a value unassigned and infer a latch.
  always_comb begin
    shreg_next = {shreg[PAT_W-2:0], bus.in_bit};
    fill_inc   = (fill == FILL_MAX) ? fill : fill + 1'b1;
    hit        = 1'b0;
    // in_valid gates first, so an undriven in_bit on idle cycles cannot
    // leak into the match decision.
    if (bus.in_valid && (fill >= FILL_HIT) && (shreg_next == PATTERN)) begin
      hit = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order. All state, including
  // the pending match pulse, clears asynchronously. A reset mid-pattern
  // therefore drops history and any pulse at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg       <= '0;
      fill        <= '0;
      match_r     <= 1'b0;
      match_cnt_r <= '0;
    end else begin
      // The pulse lasts exactly one cycle. An idle cycle or a non-matching bit
      // drops it.
      match_r <= hit;
      if (bus.in_valid) begin
`ifdef SEQ_PATTERN_NO_OVERLAP_EN
        if (hit) begin
          shreg <= '0;
          fill  <= '0;
        end else begin
          shreg <= shreg_next;
          fill  <= fill_inc;
        end
`else
        shreg <= shreg_next;
        fill  <= fill_inc;
`endif
        if (hit && (match_cnt_r != '1)) begin
          match_cnt_r <= match_cnt_r + 1'b1;
        end
      end
    end
  end

  assign bus.match     = match_r;
  assign bus.match_cnt = match_cnt_r;
  assign bus.primed    = (fill == FILL_MAX);

endmodule : seq_pattern_detect

// File: tb/tb_seq_pattern_detect.sv
// -----------------------------------------------------------------------------
// tb_seq_pattern_detect
//
// Scoreboard bench for seq_pattern_detect. The driver issues one cycle at a
// time. After each rising edge it asks a behavioural model what the outputs
// must show and queues that answer. A monitor on the falling edge pops the
// queue and compares against the DUT.
//
// The model keeps the accepted bits in a queue. It declares a hit when at
// least PAT_W bits have arrived since the last restart and the newest PAT_W
// of them spell PATTERN. The behaviour under SEQ_PATTERN_NO_OVERLAP_EN follows
// the same macro.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seq_pattern_detect;

  localparam int               PAT_W   = 4;
  localparam logic [PAT_W-1:0] PATTERN = 4'b1011;
  localparam int               CNT_W   = 4;
  localparam int               CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic             match;
    logic [CNT_W-1:0] cnt;
    logic             primed;
  } exp_t;

  logic clk;
  logic rst_n;

  seq_pattern_detect_if #(.CNT_W(CNT_W)) bus ();

  seq_pattern_detect #(
    .PAT_W  (PAT_W),
    .PATTERN(PATTERN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;

  exp_t exp_q[$];

  // Behavioural model state
  bit hist[$];
  int m_since;
  int m_cnt;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_since = 0;
    m_cnt   = 0;
  endtask

  task automatic model_accept(input bit b, output bit hit);
    logic [PAT_W-1:0] window;
    hist.push_back(b);
    if (hist.size() > PAT_W) void'(hist.pop_front());
    if (m_since < PAT_W) m_since++;
    hit    = 1'b0;
    window = '0;
    if (m_since >= PAT_W) begin
      for (int i = 0; i < PAT_W; i++) window[i] = hist[hist.size() - 1 - i];
      hit = (window == PATTERN);
    end
    if (hit) begin
      if (m_cnt < CNT_MAX) m_cnt++;
`ifdef SEQ_PATTERN_NO_OVERLAP_EN
      hist.delete();
      m_since = 0;
`endif
    end
  endtask

  // One clock of stimulus. The expected post-edge outputs go on the scoreboard.
  task automatic cycle(input logic v, input logic b);
    exp_t e;
    bit   hit;
    @(negedge clk);
    bus.in_valid = v;
    bus.in_bit   = b;
    @(posedge clk);
    hit = 1'b0;
    if (v) model_accept(b, hit);
    e.match  = hit;
    e.cnt    = CNT_W'(m_cnt);
    e.primed = (m_since == PAT_W);
    exp_q.push_back(e);
  endtask

  task automatic accept_seq(input logic [PAT_W-1:0] first_to_last);
    // The MSB is sent first, so 4'b1011 is sent as 1,0,1,1.
    for (int i = PAT_W - 1; i >= 0; i--) cycle(1'b1, first_to_last[i]);
  endtask

  // Monitor: compares every queued expectation against the DUT outputs.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("match",     32'(bus.match),     32'(e.match));
      check("match_cnt", 32'(bus.match_cnt), 32'(e.cnt));
      check("primed",    32'(bus.primed),    32'(e.primed));
    end
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_match"},  32'(bus.match),     32'd0);
    check({tag, "_cnt"},    32'(bus.match_cnt), 32'd0);
    check({tag, "_primed"}, 32'(bus.primed),    32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    // Reset phase with random inputs on the bus
    rst_n        = 1'b0;
    bus.in_valid = 1'($urandom);
    bus.in_bit   = 1'($urandom);
    #1;  check_zero_outputs("rst_t1");
    #14; check_zero_outputs("rst_t15");
    bus.in_valid = 1'($urandom);
    bus.in_bit   = 1'($urandom);
    #9;  check_zero_outputs("rst_t24");
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
    #1;  rst_n = 1'b1;

    // Single match
    accept_seq(4'b1011);
    cycle(1'b0, 1'bx);
    cycle(1'b0, 1'bx);

    // Overlap: 1,0,1,1,0,1,1
    accept_seq(4'b1011);
    accept_seq(4'b0110);  // sends 0,1,1,0; the last 0 is followed below
    cycle(1'b0, 1'bx);

    // Gapped input with X on idle cycles
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'bx);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'bx);
    cycle(1'b0, 1'bx);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'bx);
    cycle(1'b0, 1'bx);

    // Mid-stream asynchronous reset
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    model_reset();
    #1;  check_zero_outputs("async_rst");
    #4;  rst_n = 1'b1;
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'bx);
    accept_seq(4'b1011);
    cycle(1'b0, 1'bx);

    // Random stream
    for (int n = 0; n < 250; n++) begin
      logic v;
      v = ($urandom_range(0, 3) != 0);
      cycle(v, v ? 1'($urandom) : 1'bx);
    end

    // Saturation: 20 back-to-back patterns
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    for (int n = 0; n < 20; n++) accept_seq(4'b1011);
    cycle(1'b0, 1'bx);

    // Let the monitor drain, with a bounded wait
    repeat (3) @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("saturated_cnt", 32'(bus.match_cnt), 32'(CNT_MAX));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_seq_pattern_detect
